// File: rtl/v_issue_ctrl.sv
// v_issue_ctrl: issue FSM handing one vector instruction at a time to its functional unit.
// Parameter TIMEOUT_CYC (2..255): WAIT cycles without done before the instruction is aborted.
// Optional macro V_ISSUE_PERF_EN builds the perf counters; otherwise perf outputs are tied to 0.
// Ports:
//   clk, nrst (sync active-low)
//   instr_valid/instr_ready, instr, unit_sel, wr_en_req : instruction offer from the base core
//   start[4:0] / done[4:0] : one-hot unit handshake (valu, vmul, vred, vsldu, vlsu)
//   instr_q : latched instruction; vconfig_wr_en, wb_en : one-cycle pulses
//   busy, timeout_err (sticky), perf_instr_cnt, perf_stall_cnt
module v_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [2:0]  unit_sel,
  input  logic        wr_en_req,
  output logic [4:0]  start,
  input  logic [4:0]  done,
  output logic [31:0] instr_q,
  output logic        vconfig_wr_en,
  output logic        wb_en,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] perf_instr_cnt,
  output logic [31:0] perf_stall_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
  state_t      state, state_nx;
  logic [2:0]  sel_q;
  logic        wr_q;
  logic [7:0]  wait_cnt;
  logic        unit_ok;
  logic [4:0]  unit_oh;
  logic        done_hit;
  logic        tmo;
  assign unit_ok  = (sel_q != 3'd0) && (sel_q < 3'd6);
  assign unit_oh  = unit_ok ? 5'b00001 << (sel_q - 3'd1) : 5'b00000;
  // only the issued unit's done bit counts, and only while waiting
  assign done_hit = |(done & unit_oh);
  assign tmo      = wait_cnt == 8'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE  ? (instr_valid ? ISSUE : IDLE) :
               state == ISSUE ? (unit_ok ? WAIT : IDLE) :
               state == WAIT  ? (done_hit ? WB : tmo ? IDLE : WAIT) :
                                IDLE;
  end
  always_comb begin
    instr_ready   = state == IDLE;
    busy          = state != IDLE;
    start         = state == ISSUE ? unit_oh : 5'b00000;
    vconfig_wr_en = (state == ISSUE) && (sel_q == 3'd0);
    wb_en         = (state == WB) && wr_q;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      instr_q     <= '0;
      sel_q       <= '0;
      wr_q        <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) begin
        instr_q <= instr;
        sel_q   <= unit_sel;
        wr_q    <= wr_en_req;
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      // done on the final WAIT cycle takes priority over the abort
      if (state == WAIT && !done_hit && tmo) timeout_err <= 1'b1;
    end
  end
`ifdef V_ISSUE_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      instr_cnt <= instr_cnt + 32'((state == WB) || vconfig_wr_en);
      stall_cnt <= stall_cnt + 32'(state == WAIT);
    end
  end
  assign perf_instr_cnt = instr_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_instr_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb_v_issue_ctrl: randomized self-checking bench for v_issue_ctrl against a transaction-timeline model.
module tb_v_issue_ctrl;
  localparam int T = 8;
`ifdef V_ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [2:0]  unit_sel = '0;
  logic        wr_en_req = 1'b0;
  logic [4:0]  start;
  logic [4:0]  done = '0;
  logic [31:0] instr_q;
  logic        vconfig_wr_en, wb_en, busy, timeout_err;
  logic [31:0] perf_instr_cnt, perf_stall_cnt;
  always #5 clk = ~clk;
  v_issue_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .unit_sel(unit_sel), .wr_en_req(wr_en_req), .start(start), .done(done),
    .instr_q(instr_q), .vconfig_wr_en(vconfig_wr_en), .wb_en(wb_en), .busy(busy),
    .timeout_err(timeout_err), .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
  );
  int          n_tests = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        e_ready, e_busy, e_vc, e_wb;
  logic        e_err = 1'b0;
  logic [4:0]  e_start;
  logic [31:0] e_q = '0;
  int unsigned m_instr = 0;
  int unsigned m_stall = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("instr_ready", 32'(instr_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("start", 32'(start), 32'(e_start));
    chk("vconfig_wr_en", 32'(vconfig_wr_en), 32'(e_vc));
    chk("wb_en", 32'(wb_en), 32'(e_wb));
    chk("timeout_err", 32'(timeout_err), 32'(e_err));
    chk("instr_q", instr_q, e_q);
    if (e_ready) begin
      chk("perf_instr_cnt", perf_instr_cnt, PERF ? m_instr : 32'd0);
      chk("perf_stall_cnt", perf_stall_cnt, PERF ? m_stall : 32'd0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_idle();
    e_ready = 1'b1; e_busy = 1'b0; e_start = '0; e_vc = 1'b0; e_wb = 1'b0;
    instr_valid = 1'b0; instr = $urandom; unit_sel = 3'($urandom);
    wr_en_req = 1'($urandom); done = 5'($urandom);
  endtask
  task automatic set_busy();
    e_ready = 1'b0; e_busy = 1'b1; e_start = '0; e_vc = 1'b0; e_wb = 1'b0;
    instr_valid = 1'($urandom); instr = $urandom; unit_sel = 3'($urandom);
    wr_en_req = 1'($urandom); done = 5'($urandom);
  endtask
  // Called in an idle cycle. Done for a unit arrives n cycles after start; n > T never arrives.
  // abort_at > 1 pulls nrst low during that WAIT cycle and raises the unit's done right after.
  task automatic txn(input logic [2:0] sel, input logic wr, input int n, input logic [31:0] w,
                     input int abort_at);
    logic [4:0] oh;
    bit         timed;
    int         last;
    instr_valid = 1'b1; instr = w; unit_sel = sel; wr_en_req = wr;
    tick();
    set_busy();
    e_q = w;
    oh = (sel >= 3'd1 && sel <= 3'd5) ? 5'(1 << (sel - 3'd1)) : 5'd0;
    e_start = oh;
    e_vc = sel == 3'd0;
    if (oh == 5'd0) begin
      if (sel == 3'd0) m_instr++;
      tick();
      set_idle();
      return;
    end
    timed = n <= T;
    last = timed ? n + 1 : T + 1;
    for (int c = 2; c <= last; c++) begin
      tick();
      set_busy();
      done = (done & ~oh) | ((timed && c == n + 1) ? oh : 5'd0);
      m_stall++;
      if (c == abort_at) begin
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        set_idle();
        done = done | oh;
        e_q = '0; e_err = 1'b0; m_instr = 0; m_stall = 0;
        return;
      end
    end
    tick();
    if (timed) begin
      set_busy();
      e_wb = wr;
      m_instr++;
      tick();
    end else e_err = 1'b1;
    set_idle();
  endtask
  initial begin
    logic [2:0] sel;
    nrst = 1'b0;
    set_idle();
    tick();
    chk_en = 1'b1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr_q", instr_q, 32'd0);
    chk("rst_perf_instr", perf_instr_cnt, 32'd0);
    tick();
    set_idle();
    nrst = 1'b1;
    txn(3'd2, 1'b1, 2, 32'h1111_0001, 0);
    txn(3'd4, 1'b0, 4, 32'h1111_0002, 0);
    txn(3'd5, 1'b1, 1, 32'h1111_0003, 0);
    chk("perf3_instr", perf_instr_cnt, PERF ? 32'd3 : 32'd0);
    chk("perf3_stall", perf_stall_cnt, PERF ? 32'd7 : 32'd0);
    txn(3'd1, 1'b1, 3, 32'h0000_00A5, 0);
    chk("valu_instr_q", instr_q, 32'h0000_00A5);
    txn(3'd0, 1'b0, 0, 32'h2222_0001, 0);
    txn(3'd0, 1'b1, 0, 32'h2222_0002, 0);
    txn(3'd7, 1'b1, 0, 32'h3333_0007, 0);
    chk("illegal_perf_instr", perf_instr_cnt, PERF ? 32'd6 : 32'd0);
    txn(3'd3, 1'b1, 100, 32'h4444_0003, 0);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_stall", perf_stall_cnt, PERF ? 32'd18 : 32'd0);
    txn(3'd2, 1'b1, 100, 32'h5555_0002, 3);
    tick();
    set_idle();
    chk("abort_instr_q", instr_q, 32'd0);
    chk("abort_timeout_err", 32'(timeout_err), 32'd0);
    repeat (250) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        set_idle();
      end
      sel = 3'($urandom);
      txn(sel, 1'($urandom), int'($urandom_range(1, T + 2)), $urandom, 0);
    end
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/v_issue_ctrl.md
V_ISSUE_CTRL -- requirements
Module: v_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: the number of WAIT cycles without a done before the instruction is aborted (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 nrst  input  1  reset; synchronous, active-low.
REQ-004 instr_valid  input  1  base processor offers an instruction.
REQ-005 instr_ready  output  1  controller can accept an instruction.
REQ-006 instr  input  32  instruction word from the base processor.
REQ-007 unit_sel  input  3  decoded unit: 0 vconfig, 1 valu, 2 vmul, 3 vred, 4 vsldu, 5 vlsu, 6-7 illegal.
REQ-008 wr_en_req  input  1  decoded vector-register write enable.
REQ-009 start  output  5  one-hot start pulse; bit0 valu, bit1 vmul, bit2 vred, bit3 vsldu, bit4 vlsu.
REQ-010 done  input  5  per-unit completion, same bit order as start.
REQ-011 instr_q  output  32  latched instruction, held stable from accept until return to IDLE.
REQ-012 vconfig_wr_en  output  1  one-cycle CSR write pulse.
REQ-013 wb_en  output  1  one-cycle writeback commit pulse.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout_err  output  1  sticky abort flag.
REQ-016 perf_instr_cnt  output  32  retired-instruction count.
REQ-017 perf_stall_cnt  output  32  count of cycles spent in WAIT.

Function
REQ-018 The FSM shall have four states: IDLE, ISSUE, WAIT, WB.
REQ-019 instr_ready shall be 1 only in IDLE; an instruction is accepted on instr_valid&&instr_ready.
- On accept: latch instr, unit_sel and wr_en_req; go to ISSUE.
REQ-020 In ISSUE the controller shall act on the latched unit_sel for exactly one cycle:
- unit_sel 0: pulse vconfig_wr_en, then go to IDLE.
- unit_sel 1-5: pulse the matching start bit, clear the timeout counter, then go to WAIT.
- unit_sel 6-7: assert no outputs, then go to IDLE with no writeback.
REQ-021 In WAIT the controller shall sample only the done bit of the issued unit.
- Other done bits are ignored.
- A done asserted during the ISSUE cycle is ignored.
REQ-022 When the issued unit's done=1 in WAIT, go to WB.
REQ-023 In WB, wb_en shall equal the latched wr_en_req for one cycle, then go to IDLE.
REQ-024 The WAIT counter shall increment once per WAIT cycle.
- If it reaches TIMEOUT_CYC-1 with no done: set timeout_err, go to IDLE, no wb_en.
- If done arrives on the cycle the counter reaches TIMEOUT_CYC-1, done wins: go to WB.
REQ-025 Latency for a unit whose done arrives N cycles after start (N>=1):
- accept at edge 0, start during cycle 1, wb_en during cycle N+2, instr_ready high again during cycle N+3.
- vconfig: vconfig_wr_en during cycle 1, ready during cycle 2.
REQ-026 At most one start bit and at most one of {start, vconfig_wr_en, wb_en} shall be high in any cycle.
REQ-027 timeout_err shall clear only on reset.

Reset
REQ-028 While nrst=0 at a clock edge:
- state becomes IDLE; instr_q, the WAIT counter and both perf counters become 0.
- start, vconfig_wr_en, wb_en, busy and timeout_err become 0; instr_ready becomes 1 after the edge.
REQ-029 Reset asserted mid-operation shall abandon the instruction with no further start or wb_en pulse; done pulses arriving afterwards are ignored.

Configuration
REQ-030 Macro V_ISSUE_PERF_EN controls the performance counters.
- Defined: perf_instr_cnt increments on every WB or vconfig retirement; perf_stall_cnt increments every WAIT cycle.
- Both counters wrap at 2^32.
- Undefined: both ports remain present, tied to 0, and no counter registers are built.

Verification
REQ-031 valu instruction, unit_sel=1, wr_en_req=1, done[0] three cycles after start -> start=5'b00001 for one cycle, wb_en=1 exactly one cycle after done, then instr_ready=1.
REQ-032 vconfig, unit_sel=0 -> vconfig_wr_en for one cycle, no start, ready two cycles after accept; next instruction accepted back-to-back.
REQ-033 vred issued, done[0] pulsed and done[2] never pulsed, TIMEOUT_CYC=8 -> timeout_err=1 after 8 WAIT cycles, no wb_en, returns to IDLE.
REQ-034 vmul issued, nrst=0 for one edge while in WAIT, done[1] pulsed afterwards -> no wb_en, all outputs at reset values, instr_ready=1.
REQ-035 unit_sel=7 -> no start, no wb_en, ready after two cycles; with V_ISSUE_PERF_EN, perf_instr_cnt unchanged.
REQ-036 With V_ISSUE_PERF_EN defined, 3 retired instructions with WAIT lengths 2, 4, 1 -> perf_instr_cnt=3, perf_stall_cnt=7; without the macro, both read 0.
